pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: in-page increment, branches, page jumps and a
// bounded return stack for CALL/RET with a sticky overflow/underflow fault.
module pc_sequencer #(
  parameter int AW    = 10,
  parameter int OW    = 8,
  parameter int DEPTH = 4,
  parameter int PW    = AW - OW,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          start,
  input  logic [AW-1:0] start_address,
  input  logic          stall,
  input  logic [2:0]    cmd,
  input  logic          cond,
  input  logic [AW-1:0] target,
  input  logic [PW-1:0] page,
  output logic [AW-1:0] rp,
  output logic [SW-1:0] sp,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          fault
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    CMD_SEQ   = 3'd0,
    CMD_BR    = 3'd1,
    CMD_JABS  = 3'd2,
    CMD_CALL  = 3'd3,
    CMD_RET   = 3'd4,
    CMD_JPAGE = 3'd5
  } cmd_e;

  logic [AW-1:0] stack_mem [DEPTH];
  logic [AW-1:0] npc;
  logic [AW-1:0] rp_next;
  logic [SW-1:0] sp_next;
  logic [SW-1:0] sp_dec;
  logic          fault_next;
  logic          push;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign npc         = {rp[AW-1:OW], rp[OW-1:0] + OW'(1)};
  assign stack_full  = (sp == SW'(DEPTH));
  assign stack_empty = (sp == '0);
  assign sp_dec      = sp - SW'(1);
  assign wr_idx      = sp[IW-1:0];
  assign rd_idx      = sp_dec[IW-1:0];

  // NOTE: every output of this block gets a default first so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    rp_next    = npc;
    sp_next    = sp;
    fault_next = fault;
    push       = 1'b0;
    case (cmd_e'(cmd))
      CMD_BR:    if (cond) rp_next = {rp[AW-1:OW], target[OW-1:0]};
      CMD_JABS:  rp_next = target;
      CMD_JPAGE: rp_next = {page, target[OW-1:0]};
      CMD_CALL: begin
        if (!stack_full) begin
          push    = 1'b1;
          sp_next = sp + SW'(1);
          rp_next = target;
        end else begin
          fault_next = 1'b1;
        end
      end
      CMD_RET: begin
        if (!stack_empty) begin
          rp_next = stack_mem[rd_idx];
          sp_next = sp_dec;
        end else begin
          fault_next = 1'b1;
        end
      end
      default: ;  // SEQ and reserved codes just advance
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (start) begin
      rp    <= start_address;
      sp    <= '0;
      fault <= 1'b0;
    end else if (!stall) begin
      rp    <= rp_next;
      sp    <= sp_next;
      fault <= fault_next;
    end
  end

  // NOTE: the stack array is deliberately not reset; entries above sp are
  // never read, so clearing them would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (!start && !stall && push) stack_mem[wr_idx] <= npc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one task per feature, expected values
// computed by hand from the command semantics.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       start = 1'b0;
  logic [9:0] start_address = '0;
  logic       stall = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic       cond = 1'b0;
  logic [9:0] target = '0;
  logic [1:0] page = '0;
  logic [9:0] rp;
  logic [2:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       fault;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JABS = 3'd2, CALL = 3'd3,
                         RET = 3'd4, JPAGE = 3'd5;

  pc_sequencer #(.AW(10), .OW(8), .DEPTH(4)) dut (
    .clk(clk), .start(start), .start_address(start_address), .stall(stall),
    .cmd(cmd), .cond(cond), .target(target), .page(page), .rp(rp), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] addr);
    start = 1'b1; start_address = addr; stall = 1'b0; cmd = SEQ;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [9:0] t);
    cmd = c; target = t;
    tick();
  endtask

  task automatic test_reset_wrap();
    do_start(10'h2FE);
    total++; if (rp !== 10'h2FE) $display("FAIL reset_rp: got %h expected %h", rp, 10'h2FE); else passed++;
    total++; if (sp !== 3'd0) $display("FAIL reset_sp: got %0d expected 0", sp); else passed++;
    total++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b expected 1/0", stack_empty, stack_full); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", fault); else passed++;
    issue(SEQ, 10'h000);
    total++; if (rp !== 10'h2FF) $display("FAIL wrap_seq1: got %h expected %h", rp, 10'h2FF); else passed++;
    issue(SEQ, 10'h000);
    total++; if (rp !== 10'h200) $display("FAIL wrap_seq2: got %h expected %h", rp, 10'h200); else passed++;
    issue(SEQ, 10'h000);
    total++; if (rp !== 10'h201) $display("FAIL wrap_seq3: got %h expected %h", rp, 10'h201); else passed++;
  endtask

  task automatic test_branch_page();
    do_start(10'h105);
    cond = 1'b0; issue(BR, 10'h3A0);
    total++; if (rp !== 10'h106) $display("FAIL br_not_taken: got %h expected %h", rp, 10'h106); else passed++;
    cond = 1'b1; issue(BR, 10'h3A0);
    total++; if (rp !== 10'h1A0) $display("FAIL br_taken: got %h expected %h", rp, 10'h1A0); else passed++;
    cond = 1'b0; page = 2'd3; issue(JPAGE, 10'h044);
    total++; if (rp !== 10'h344) $display("FAIL jpage: got %h expected %h", rp, 10'h344); else passed++;
    page = 2'd0; issue(JABS, 10'h0C7);
    total++; if (rp !== 10'h0C7) $display("FAIL jabs: got %h expected %h", rp, 10'h0C7); else passed++;
  endtask

  task automatic test_nested_calls();
    do_start(10'h010);
    issue(CALL, 10'h100);
    total++; if (rp !== 10'h100 || sp !== 3'd1) $display("FAIL call1: got rp=%h sp=%0d expected 100/1", rp, sp); else passed++;
    issue(CALL, 10'h200);
    total++; if (rp !== 10'h200 || sp !== 3'd2) $display("FAIL call2: got rp=%h sp=%0d expected 200/2", rp, sp); else passed++;
    issue(RET, 10'h3FF);
    total++; if (rp !== 10'h101 || sp !== 3'd1) $display("FAIL ret1: got rp=%h sp=%0d expected 101/1", rp, sp); else passed++;
    issue(RET, 10'h3FF);
    total++; if (rp !== 10'h011 || sp !== 3'd0) $display("FAIL ret2: got rp=%h sp=%0d expected 011/0", rp, sp); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL nested_fault: got %b expected 0", fault); else passed++;
  endtask

  task automatic test_overflow_underflow();
    do_start(10'h000);
    issue(CALL, 10'h040);
    issue(CALL, 10'h080);
    issue(CALL, 10'h0C0);
    issue(CALL, 10'h100);
    total++; if (sp !== 3'd4 || stack_full !== 1'b1 || fault !== 1'b0) $display("FAIL fill: got sp=%0d full=%b fault=%b expected 4/1/0", sp, stack_full, fault); else passed++;
    issue(CALL, 10'h300);
    total++; if (rp !== 10'h101 || sp !== 3'd4) $display("FAIL overflow_rp: got rp=%h sp=%0d expected 101/4", rp, sp); else passed++;
    total++; if (fault !== 1'b1) $display("FAIL overflow_fault: got %b expected 1", fault); else passed++;
    issue(SEQ, 10'h000);
    total++; if (fault !== 1'b1 || rp !== 10'h102) $display("FAIL fault_sticky: got fault=%b rp=%h expected 1/102", fault, rp); else passed++;
    issue(RET, 10'h000);
    total++; if (rp !== 10'h0C1 || sp !== 3'd3) $display("FAIL ret_top: got rp=%h sp=%0d expected 0C1/3", rp, sp); else passed++;
    do_start(10'h050);
    total++; if (fault !== 1'b0 || sp !== 3'd0) $display("FAIL start_clear: got fault=%b sp=%0d expected 0/0", fault, sp); else passed++;
    issue(RET, 10'h200);
    total++; if (rp !== 10'h051 || sp !== 3'd0 || fault !== 1'b1) $display("FAIL underflow: got rp=%h sp=%0d fault=%b expected 051/0/1", rp, sp, fault); else passed++;
  endtask

  task automatic test_stall();
    do_start(10'h020);
    issue(CALL, 10'h1F0);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; cond = 1'b1;
      issue(CALL, 10'h300);
      total++; if (rp !== 10'h1F0 || sp !== 3'd1) $display("FAIL stall_hold%0d: got rp=%h sp=%0d expected 1F0/1", i, rp, sp); else passed++;
    end
    stall = 1'b0; cond = 1'b0;
    issue(RET, 10'h000);
    total++; if (rp !== 10'h021 || sp !== 3'd0) $display("FAIL stall_ret: got rp=%h sp=%0d expected 021/0", rp, sp); else passed++;
    issue(CALL, 10'h222);
    stall = 1'b1; start = 1'b1; start_address = 10'h3AB;
    issue(CALL, 10'h111);
    start = 1'b0; stall = 1'b0;
    total++; if (rp !== 10'h3AB || sp !== 3'd0 || fault !== 1'b0) $display("FAIL stall_start: got rp=%h sp=%0d fault=%b expected 3AB/0/0", rp, sp, fault); else passed++;
    issue(RET, 10'h000);
    total++; if (rp !== 10'h3AC || fault !== 1'b1) $display("FAIL start_discard: got rp=%h fault=%b expected 3AC/1", rp, fault); else passed++;
  endtask

  task automatic test_reserved();
    do_start(10'h0FF);
    issue(3'd6, 10'h2AA);
    total++; if (rp !== 10'h000 || sp !== 3'd0 || fault !== 1'b0) $display("FAIL reserved6: got rp=%h sp=%0d fault=%b expected 000/0/0", rp, sp, fault); else passed++;
    issue(3'd7, 10'h2AA);
    total++; if (rp !== 10'h001 || fault !== 1'b0) $display("FAIL reserved7: got rp=%h fault=%b expected 001/0", rp, fault); else passed++;
  endtask

  task automatic test_back_to_back();
    do_start(10'h3FE);
    issue(CALL, 10'h123);
    total++; if (rp !== 10'h123 || sp !== 3'd1) $display("FAIL b2b_call: got rp=%h sp=%0d expected 123/1", rp, sp); else passed++;
    issue(RET, 10'h000);
    total++; if (rp !== 10'h3FF || sp !== 3'd0) $display("FAIL b2b_ret: got rp=%h sp=%0d expected 3FF/0", rp, sp); else passed++;
    issue(SEQ, 10'h000);
    total++; if (rp !== 10'h300) $display("FAIL b2b_wrap: got %h expected %h", rp, 10'h300); else passed++;
  endtask

  initial begin
    test_reset_wrap();
    test_branch_page();
    test_nested_calls();
    test_overflow_underflow();
    test_stall();
    test_reserved();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
